// File: rtl/b2_row_accum_pkg.sv
// b2_pkg: shared widths, FSM state type and the ReLU/requant/saturate helper
// for the Block2 row accumulation stage.
package b2_pkg;

    localparam int IN_W  = 7;
    localparam int ACC_W = 11;
    localparam int OUT_W = 7;

    localparam logic signed [ACC_W-1:0] QMAX = ACC_W'((1 << OUT_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // ReLU, arithmetic right shift, clamp to the unsigned output range.
    function automatic logic [OUT_W-1:0] relu_sat(
        input logic signed [ACC_W-1:0] s,
        input int unsigned             sh
    );
        logic signed [ACC_W-1:0] q;
        q = s >>> sh;
        if (s[ACC_W-1]) return '0;
        if (q > QMAX) return '1;
        return q[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/b2_row_accum_if.sv
// b2_row_accum_if: frame control, PE row results in, activations out.
// master drives start/bias/row_val/row_res; slave (the block) drives the rest.
interface b2_row_accum_if
    import b2_pkg::*;
#(
    parameter int ROWS = 3
) ();

    logic                    start;
    logic signed [ACC_W-1:0] bias;
    logic [ROWS-1:0]         row_val;
    logic [ROWS*IN_W-1:0]    row_res;
    logic [OUT_W-1:0]        out_data;
    logic                    out_val;
    logic                    frame_done;
    logic                    busy;
    logic                    err_misalign;

    modport master (
        output start, bias, row_val, row_res,
        input  out_data, out_val, frame_done, busy, err_misalign
    );

    modport slave (
        input  start, bias, row_val, row_res,
        output out_data, out_val, frame_done, busy, err_misalign
    );

endinterface

// File: rtl/b2_row_accum_skew_delay.sv
// skew_delay: DEPTH-stage shift register of {val, res}; DEPTH 0 is a wire.
// Ports: clk, rst_n, clr (sync flush), in_val/in_res, out_val/out_res.
module skew_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_val,
    input  logic [W-1:0] in_res,
    output logic         out_val,
    output logic [W-1:0] out_res
);

    if (DEPTH == 0) begin : g_pass
        logic unused_pass;
        assign unused_pass = clk ^ rst_n ^ clr;
        assign out_val = in_val;
        assign out_res = in_res;
    end else begin : g_sr
        logic [DEPTH-1:0]        v;
        logic [DEPTH-1:0][W-1:0] r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= '0;
                r <= '0;
            end else if (clr) begin
                v <= '0;
                r <= '0;
            end else begin
                v[0] <= in_val;
                r[0] <= in_res;
                for (int i = 1; i < DEPTH; i++) begin
                    v[i] <= v[i-1];
                    r[i] <= r[i-1];
                end
            end
        end

        assign out_val = v[DEPTH-1];
        assign out_res = r[DEPTH-1];
    end

endmodule

// File: rtl/b2_row_accum.sv
// b2_row_accum: deskews PE row results, sums them plus a per-frame bias,
// then ReLU / >>>SHIFT / saturate and streams activations with frame flags.
// Ports: clk, rst_n (async, active-low), bus (b2_row_accum_if.slave).
// Optional B2_MAXPOOL_EN: stride-2 max-pool, OUT_LEN/2 outputs per frame.
module b2_row_accum
    import b2_pkg::*;
#(
    parameter int ROWS     = 3,
    parameter int ROW_SKEW = 1,
    parameter int SHIFT    = 2,
    parameter int OUT_LEN  = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    b2_row_accum_if.slave  bus
);

    localparam int CW = $clog2(OUT_LEN + 1);

    state_t                       state;
    logic                         run;
    logic                         clr;
    logic [ROWS-1:0]              d_val;
    logic [ROWS-1:0][IN_W-1:0]    d_res;
    logic                         all_v;
    logic                         any_v;
    logic                         acc;
    logic [CW-1:0]                cnt;
    logic signed [ACC_W-1:0]      bias_q;
    logic signed [ACC_W-1:0]      sum_c;
    logic signed [ACC_W-1:0]      sum_q;
    logic                         s1_v;
    logic                         s1_last;
    logic                         s2_v;
    logic                         s2_last;
    logic [OUT_W-1:0]             s2_act;
    logic                         fin_v;
    logic                         fin_last;
    logic [OUT_W-1:0]             fin_data;
    logic                         busy_q;
    logic                         done_q;
    logic                         err_q;

    assign run = (state == S_RUN);
    assign clr = (state == S_IDLE) && bus.start;

    // Row k waits (ROWS-1-k)*ROW_SKEW cycles so all rows line up with the last.
    for (genvar k = 0; k < ROWS; k++) begin : g_row
        skew_delay #(
            .DEPTH ((ROWS - 1 - k) * ROW_SKEW),
            .W     (IN_W)
        ) u_dly (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .in_val  (bus.row_val[k] & run),
            .in_res  (bus.row_res[k*IN_W +: IN_W]),
            .out_val (d_val[k]),
            .out_res (d_res[k])
        );
    end

    assign all_v = &d_val;
    assign any_v = |d_val;
    assign acc   = run && all_v && (cnt < CW'(OUT_LEN));

    always_comb begin
        sum_c = bias_q;
        for (int k = 0; k < ROWS; k++) begin
            sum_c = sum_c + {{(ACC_W-IN_W){d_res[k][IN_W-1]}}, d_res[k]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s2_act  <= '0;
            s2_v    <= 1'b0;
            s2_last <= 1'b0;
        end else begin
            s1_v    <= acc;
            s1_last <= acc && (cnt == CW'(OUT_LEN - 1));
            if (acc) sum_q <= sum_c;
            s2_v    <= s1_v;
            s2_last <= s1_last;
            if (s1_v) s2_act <= relu_sat(sum_q, SHIFT);
        end
    end

`ifdef B2_MAXPOOL_EN
    logic             ph;
    logic [OUT_W-1:0] hold;

    // First of each pair is parked in hold; the second emits the max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= 1'b0;
            hold     <= '0;
            fin_v    <= 1'b0;
            fin_last <= 1'b0;
            fin_data <= '0;
        end else begin
            fin_v    <= 1'b0;
            fin_last <= 1'b0;
            if (clr) begin
                ph <= 1'b0;
            end else if (s2_v) begin
                if (!ph) begin
                    hold <= s2_act;
                    ph   <= 1'b1;
                end else begin
                    fin_v    <= 1'b1;
                    fin_last <= s2_last;
                    fin_data <= (s2_act > hold) ? s2_act : hold;
                    ph       <= 1'b0;
                end
            end
        end
    end
`else
    assign fin_v    = s2_v;
    assign fin_last = s2_last;
    assign fin_data = s2_act;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            bias_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_RUN;
                        bias_q <= bus.bias;
                        cnt    <= '0;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (acc) cnt <= cnt + CW'(1);
                    if (any_v && !all_v) err_q <= 1'b1;
                    if (fin_v && fin_last) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_data     = fin_data;
    assign bus.out_val      = fin_v;
    assign bus.frame_done   = done_q;
    assign bus.busy         = busy_q;
    assign bus.err_misalign = err_q;

endmodule

// File: tb/tb_b2_row_accum.sv
// tb_b2_row_accum: directed table-driven bench for b2_row_accum (OUT_LEN=4),
// plus hand sequences for pairing, misalignment, mid-frame start and reset.
module tb_b2_row_accum;
    import b2_pkg::*;

    localparam int OUT_LEN = 4;
`ifdef B2_MAXPOOL_EN
    localparam bit POOL = 1'b1;
`else
    localparam bit POOL = 1'b0;
`endif
    localparam int NOUT = POOL ? OUT_LEN / 2 : OUT_LEN;
    localparam int LAT0 = POOL ? 4 : 2;

    typedef struct packed {
        logic signed [IN_W-1:0] r2;
        logic signed [IN_W-1:0] r1;
        logic signed [IN_W-1:0] r0;
    } samp_t;

    typedef struct packed {
        samp_t                   s;
        logic signed [ACC_W-1:0] b;
        logic [OUT_W-1:0]        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    int               oq_cyc[$];
    logic [OUT_W-1:0] oq_dat[$];
    logic             oq_busy[$];
    int               fd_n;
    int               fd_cyc;
    logic             fd_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    b2_row_accum_if #(.ROWS(3)) bus ();

    b2_row_accum #(
        .ROWS     (3),
        .ROW_SKEW (1),
        .SHIFT    (2),
        .OUT_LEN  (OUT_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always @(negedge clk) begin
        if (bus.out_val) begin
            oq_cyc.push_back(cyc);
            oq_dat.push_back(bus.out_data);
            oq_busy.push_back(bus.busy);
        end
        if (bus.frame_done) begin
            fd_n++;
            fd_cyc  = cyc;
            fd_busy = bus.busy;
        end
    end

    function automatic void chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", n, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(
        input  samp_t                   fr [4],
        input  logic signed [ACC_W-1:0] b,
        input  int                      mid_start,
        input  bit                      bad,
        input  int                      rst_at,
        output int                      r2c
    );
        int off;
        int s;
        int hold_n;
        bit did;
        off    = bad ? 4 : 0;
        hold_n = 0;
        did    = 1'b0;
        r2c    = -1;
        oq_cyc.delete();
        oq_dat.delete();
        oq_busy.delete();
        fd_n = 0;
        bus.bias  = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", int'(bus.busy), 1);
        for (int j = 0; j < 16 + off; j++) begin
            bus.row_val = '0;
            bus.row_res = '0;
            if (bad && j == 0) begin
                bus.row_val[0]      = 1'b1;
                bus.row_res[IN_W-1:0] = 7'd9;
            end
            for (int k = 0; k < 3; k++) begin
                s = j - off - k;
                if (s >= 0 && s < 4) begin
                    bus.row_val[k] = 1'b1;
                    bus.row_res[k*IN_W +: IN_W] =
                        (k == 0) ? fr[s].r0 : (k == 1) ? fr[s].r1 : fr[s].r2;
                end
            end
            if (j - off == 2) r2c = cyc;
            if (j == mid_start) begin
                bus.start = 1'b1;
                bus.bias  = 11'sd100;
            end
            if (bad && j == off) begin
                chk("err_misalign_set", int'(bus.err_misalign), 1);
                chk("no_out_on_misalign", oq_dat.size(), 0);
            end
            tick();
            bus.start = 1'b0;
            if (hold_n > 0) begin
                hold_n--;
                if (hold_n == 0) rst_n = 1'b1;
            end else if (rst_at > 0 && !did && bus.out_val &&
                         oq_dat.size() == rst_at - 1) begin
                did   = 1'b1;
                rst_n = 1'b0;
                #1;
                chk("rst_out_val", int'(bus.out_val), 0);
                chk("rst_out_data", int'(bus.out_data), 0);
                chk("rst_busy", int'(bus.busy), 0);
                chk("rst_frame_done", int'(bus.frame_done), 0);
                chk("rst_err", int'(bus.err_misalign), 0);
                hold_n = 2;
            end
        end
        bus.row_val = '0;
        bus.row_res = '0;
        rst_n = 1'b1;
        if (rst_at > 0) chk("rst_happened", int'(did), 1);
    endtask

    task automatic check_frame(
        input string            n,
        input logic [OUT_W-1:0] eu [4],
        input bit               bad,
        input int               r2c
    );
        int e[4];
        for (int i = 0; i < NOUT; i++) begin
            if (POOL) e[i] = (eu[2*i] > eu[2*i+1]) ? eu[2*i] : eu[2*i+1];
            else      e[i] = eu[i];
        end
        chk({n, "_count"}, oq_dat.size(), NOUT);
        for (int i = 0; i < NOUT; i++) begin
            if (i < oq_dat.size())
                chk($sformatf("%s_data%0d", n, i), int'(oq_dat[i]), e[i]);
        end
        if (oq_dat.size() > 0) begin
            chk({n, "_latency"}, oq_cyc[0] - r2c, LAT0);
            chk({n, "_busy_last_out"}, int'(oq_busy[$]), 1);
            chk({n, "_fd_gap"}, fd_cyc - oq_cyc[$], 1);
        end
        chk({n, "_fd_pulses"}, fd_n, 1);
        chk({n, "_busy_at_fd"}, int'(fd_busy), 0);
        chk({n, "_err"}, int'(bus.err_misalign), int'(bad));
    endtask

    vec_t             tbl [10];
    samp_t            fr  [4];
    logic [OUT_W-1:0] eu  [4];
    samp_t            sa;
    samp_t            sb;
    int               r2c;

    initial begin
        tbl[0] = '{s: '{r2: 7'sd30,  r1: 7'sd20,  r0: 7'sd10},  b: 11'sd4,   e: 7'd16};
        tbl[1] = '{s: '{r2: 7'sd5,   r1: -7'sd10, r0: -7'sd50}, b: 11'sd0,   e: 7'd0};
        tbl[2] = '{s: '{r2: 7'sd63,  r1: 7'sd63,  r0: 7'sd63},  b: 11'sd400, e: 7'd127};
        tbl[3] = '{s: '{r2: 7'sd63,  r1: 7'sd63,  r0: 7'sd63},  b: 11'sd318, e: 7'd126};
        tbl[4] = '{s: '{r2: 7'sd63,  r1: 7'sd63,  r0: 7'sd63},  b: 11'sd322, e: 7'd127};
        tbl[5] = '{s: '{r2: 7'sd63,  r1: 7'sd63,  r0: 7'sd63},  b: 11'sd323, e: 7'd127};
        tbl[6] = '{s: '{r2: -7'sd64, r1: -7'sd64, r0: -7'sd64}, b: 11'sd300, e: 7'd27};
        tbl[7] = '{s: '{r2: 7'sd3,   r1: 7'sd2,   r0: 7'sd1},   b: 11'sd2,   e: 7'd2};
        tbl[8] = '{s: '{r2: 7'sd20,  r1: 7'sd20,  r0: 7'sd20},  b: -11'sd56, e: 7'd1};
        tbl[9] = '{s: '{r2: 7'sd0,   r1: 7'sd0,   r0: -7'sd3},  b: 11'sd0,   e: 7'd0};

        bus.start   = 1'b0;
        bus.bias    = '0;
        bus.row_val = '0;
        bus.row_res = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_out_data", int'(bus.out_data), 0);
        chk("reset_out_val", int'(bus.out_val), 0);
        chk("reset_frame_done", int'(bus.frame_done), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_err", int'(bus.err_misalign), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 4; i++) begin
                fr[i] = tbl[v].s;
                eu[i] = tbl[v].e;
            end
            run_frame(fr, tbl[v].b, -1, 1'b0, 0, r2c);
            check_frame($sformatf("vec%0d", v), eu, 1'b0, r2c);
            tick();
        end

        // 16,5,16,5 with a start pulse mid-frame that must be ignored
        sa = tbl[0].s;
        sb = '{r2: 7'sd6, r1: 7'sd5, r0: 7'sd5};
        fr = '{sa, sb, sa, sb};
        eu = '{7'd16, 7'd5, 7'd16, 7'd5};
        run_frame(fr, 11'sd4, 3, 1'b0, 0, r2c);
        check_frame("pair_midstart", eu, 1'b0, r2c);
        tick();

        // lone row 0 before a full frame: sticky error, counter unaffected
        for (int i = 0; i < 4; i++) begin
            fr[i] = tbl[0].s;
            eu[i] = 7'd16;
        end
        run_frame(fr, 11'sd4, -1, 1'b1, 0, r2c);
        check_frame("misalign", eu, 1'b1, r2c);
        tick();
        tick();
        chk("err_sticky_idle", int'(bus.err_misalign), 1);

        // next start clears the error
        run_frame(fr, 11'sd4, -1, 1'b0, 0, r2c);
        check_frame("after_misalign", eu, 1'b0, r2c);
        tick();

        // async reset on an output aborts the frame with no frame_done
        run_frame(fr, 11'sd4, -1, 1'b0, POOL ? 1 : 2, r2c);
        chk("rst_out_count", oq_dat.size(), POOL ? 0 : 1);
        chk("rst_no_fd", fd_n, 0);
        chk("rst_idle_busy", int'(bus.busy), 0);
        tick();

        run_frame(fr, 11'sd4, -1, 1'b0, 0, r2c);
        check_frame("post_reset", eu, 1'b0, r2c);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/b2_row_accum.md
# b2_row_accum

Downstream accumulation stage for the Block2 PE array. Each PE row delivers one signed 7-bit partial sum per output position, staggered by a fixed skew row-to-row. This block realigns the row results, sums them, adds a per-frame bias, and applies ReLU, an arithmetic right-shift requantization and unsigned saturation. It then streams 7-bit activations, with frame bookkeeping, to the next layer's slide-data buffer.

## Interface
- ROWS, 3, number of PE rows (kernel taps) summed
- IN_W, 7, width of each signed row result
- ACC_W, 11, signed accumulator width; must cover ROWS·2^(IN_W-1) + |bias|
- OUT_W, 7, unsigned output activation width
- ROW_SKEW, 1, cycles by which row k+1 lags row k for the same output position
- SHIFT, 2, requantization right-shift amount
- OUT_LEN, 64, pre-pool output positions per frame (even when pooling is compiled in)
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- start  in  1  one-cycle pulse; begins a frame and latches bias
- bias  in  ACC_W  signed bias, sampled on start
- row_val  in  ROWS  per-row result valid
- row_res  in  ROWS·IN_W  signed row results, row k at bits [k·IN_W +: IN_W]
- out_data  out  OUT_W  unsigned activation
- out_val  out  1  out_data valid, single cycle per activation
- frame_done  out  1  one-cycle pulse after the last activation of a frame
- busy  out  1  high from the cycle after start until frame_done
- err_misalign  out  1  sticky; set when aligned valids disagree

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE→RUN on start: latch bias, clear the position counter, delay lines and err_misalign.
- RUN→DONE when the OUT_LEN-th position has been emitted. DONE→IDLE unconditionally after one cycle, with frame_done=1 in DONE.
- start in RUN or DONE is ignored. row_val in IDLE or DONE is ignored, and no output is produced.
- Alignment: row k passes through a (ROWS-1-k)·ROW_SKEW stage delay of {val, res}. Row ROWS-1 is undelayed.
- Aligned sample: all delayed valids are 1, giving a valid sum.
- Partial sample: some delayed valids are 1 but not all. The block sets err_misalign, discards the sample and does not advance the counter.
- Arithmetic: each row result is sign-extended to ACC_W; sum = Σrow + bias.
  - ReLU: sum<0 → 0.
  - Requantize: q = sum >>> SHIFT (truncating).
  - Saturate: q > 2^OUT_W-1 → 2^OUT_W-1.
- The position counter increments on each accepted aligned sample and saturates at OUT_LEN.

## Timing
- Reset values: out_data=0, out_val=0, frame_done=0, busy=0, err_misalign=0, FSM=IDLE, delay lines and counter cleared.
- Latency: an aligned sample forms in the cycle row ROWS-1 is valid.
  - Stage 1 registers the sum.
  - Stage 2 registers the ReLU/shift/saturate result.
  - out_val therefore rises 2 cycles after the row ROWS-1 valid.
- Throughput: one activation per cycle. There is no backpressure, and the consumer must accept every out_val.
- frame_done asserts in the cycle after the final out_val.
- busy deasserts in the same cycle as frame_done.
- Asynchronous reset mid-frame aborts the frame immediately. No partial frame_done is emitted.

## Configuration
- B2_MAXPOOL_EN defined: stride-2 max-pool on post-ReLU activations.
  - The first of each pair is held internally.
  - out_val fires on the second of the pair with the max of the two, one cycle later than the unpooled latency.
  - The frame produces OUT_LEN/2 activations.
  - frame_done follows the last pooled out_val.
- B2_MAXPOOL_EN undefined: every accepted position is emitted, OUT_LEN activations per frame, with no pooling logic.

## Structure
- Shared package b2_pkg holds:
  - width constants IN_W, ACC_W and OUT_W
  - the FSM state typedef
  - the sat/ReLU helper function
- One sub-module, skew_delay: a parameterized-depth shift register carrying {val, res}, instantiated per row. Depth 0 is a pass-through.

## Test plan
- ROWS=3, ROW_SKEW=1, SHIFT=2, bias=4; row results 10,20,30 presented with correct skew → out_data=16, 2 cycles after the row 2 valid.
- Row results -50,-10,5, bias=0 → sum -55, ReLU → out_data=0 with out_val=1.
- Row results 63,63,63, bias=400 → sum 589, 589>>>2=147 → saturated out_data=127.
- Row 0 valid without row 1/row 2 at the aligned time → err_misalign=1 and stays set, no out_val, counter unchanged. Next start clears it.
- OUT_LEN=4, four aligned samples → four out_val pulses, frame_done 1 cycle after the 4th, busy falls with it. start mid-frame is ignored; reset at the 2nd output clears all outputs to 0.
- B2_MAXPOOL_EN with activations 16 then 5 → single out_val with out_data=16. OUT_LEN=4 → two pooled outputs, then frame_done.
